// File: rtl/wb_mux_pkg.sv
// Shared types and constants for the Wishbone 1-to-N mux with fault capture.
// Contents: bus-cycle state enum, Wishbone cycle-type (cti) codes, and a
// helper that sizes slave-index fields (minimum one bit).
// Optional feature macro used by the mux: WB_MUX_TMO_TIMEOUT_EN.
package wb_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FAULT  = 2'd2,
        WAIT   = 2'd3
    } state_e;

    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] INCR    = 3'b010;
    localparam logic [2:0] EOB     = 3'b111;

    // Width of a slave index; a single slave still gets a one-bit field.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decoder for the Wishbone mux.
// Ports:
//   adr_i  : address to decode
//   hit_o  : some slot matched ((adr & mask) == base)
//   idx_o  : index of the matching slot; lowest index wins on multiple hits
module wb_addr_decode
    import wb_mux_pkg::*;
#(
    parameter int unsigned                  aw         = 32,
    parameter int unsigned                  num_slaves = 2,
    parameter logic [num_slaves*aw-1:0]     match_addr = '0,
    parameter logic [num_slaves*aw-1:0]     match_mask = '0
) (
    input  logic [aw-1:0]                        adr_i,
    output logic                                 hit_o,
    output logic [idx_width(num_slaves)-1:0]     idx_o
);

    localparam int unsigned IDXW = idx_width(num_slaves);

    // Scan from the top so the lowest matching slot is the last assignment.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = int'(num_slaves) - 1; i >= 0; i--) begin
            if ((adr_i & match_mask[i*aw +: aw]) == match_addr[i*aw +: aw]) begin
                hit_o = 1'b1;
                idx_o = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/wb_mux_tmo.sv
// Wishbone 1-master to num_slaves-slave mux with bus-error generation.
// The slave is chosen once per bus cycle and held until wbm_cyc_i drops.
// Unmapped addresses (and, with WB_MUX_TMO_TIMEOUT_EN defined, slaves that
// stall for `timeout` cycles) produce a one-cycle wbm_err_o / fault_o and the
// faulting address is kept in fault_adr_o.
// Ports:
//   wb_clk_i, wb_rst_i         : clock, synchronous active-low reset
//   wbm_*_i / wbm_*_o          : master request in, response out
//   wbs_*_o (broadcast)        : adr/dat/sel/we/cti/bte copied to all slaves
//   wbs_cyc_o, wbs_stb_o       : per-slave strobes, one-hot or zero
//   wbs_dat_i/ack_i/err_i/rty_i: slave responses
//   fault_o, fault_adr_o       : internal-error pulse and captured address
module wb_mux_tmo
    import wb_mux_pkg::*;
#(
    parameter int unsigned                  dw         = 32,
    parameter int unsigned                  aw         = 32,
    parameter int unsigned                  num_slaves = 2,
    parameter logic [num_slaves*aw-1:0]     match_addr = '0,
    parameter logic [num_slaves*aw-1:0]     match_mask = '0,
    parameter int unsigned                  timeout    = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [aw-1:0]             wbm_adr_i,
    input  logic [dw-1:0]             wbm_dat_i,
    input  logic [3:0]                wbm_sel_i,
    input  logic                      wbm_we_i,
    input  logic                      wbm_cyc_i,
    input  logic                      wbm_stb_i,
    input  logic [2:0]                wbm_cti_i,
    input  logic [1:0]                wbm_bte_i,
    output logic [dw-1:0]             wbm_dat_o,
    output logic                      wbm_ack_o,
    output logic                      wbm_err_o,
    output logic                      wbm_rty_o,
    output logic [aw-1:0]             wbs_adr_o,
    output logic [dw-1:0]             wbs_dat_o,
    output logic [3:0]                wbs_sel_o,
    output logic                      wbs_we_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    output logic [num_slaves-1:0]     wbs_cyc_o,
    output logic [num_slaves-1:0]     wbs_stb_o,
    input  logic [num_slaves*dw-1:0]  wbs_dat_i,
    input  logic [num_slaves-1:0]     wbs_ack_i,
    input  logic [num_slaves-1:0]     wbs_err_i,
    input  logic [num_slaves-1:0]     wbs_rty_i,
    output logic                      fault_o,
    output logic [aw-1:0]             fault_adr_o
);

    localparam int unsigned IDXW = idx_width(num_slaves);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   sel_q, sel_d;
    logic [aw-1:0]     fault_adr_q, fault_adr_d;

    logic              dec_hit;
    logic [IDXW-1:0]   dec_idx;
    logic              s_ack, s_err, s_rty;
    logic [dw-1:0]     s_dat;
    logic              tmo_hit;

    wb_addr_decode #(
        .aw         (aw),
        .num_slaves (num_slaves),
        .match_addr (match_addr),
        .match_mask (match_mask)
    ) u_dec (
        .adr_i (wbm_adr_i),
        .hit_o (dec_hit),
        .idx_o (dec_idx)
    );

    // Request fields go to every slave unchanged.
    assign wbs_adr_o = wbm_adr_i;
    assign wbs_dat_o = wbm_dat_i;
    assign wbs_sel_o = wbm_sel_i;
    assign wbs_we_o  = wbm_we_i;
    assign wbs_cti_o = wbm_cti_i;
    assign wbs_bte_o = wbm_bte_i;

    // Route strobes to, and responses from, the locked slave while ACTIVE.
    always_comb begin
        wbs_cyc_o = '0;
        wbs_stb_o = '0;
        s_ack     = 1'b0;
        s_err     = 1'b0;
        s_rty     = 1'b0;
        s_dat     = '0;
        for (int i = 0; i < int'(num_slaves); i++) begin
            if (state_q == ACTIVE && sel_q == IDXW'(i)) begin
                wbs_cyc_o[i] = wbm_cyc_i;
                wbs_stb_o[i] = wbm_stb_i;
                s_ack        = wbs_ack_i[i];
                s_err        = wbs_err_i[i];
                s_rty        = wbs_rty_i[i];
                s_dat        = wbs_dat_i[i*dw +: dw];
            end
        end
    end

    assign wbm_ack_o   = s_ack;
    assign wbm_err_o   = s_err | (state_q == FAULT);
    assign wbm_rty_o   = s_rty;
    assign wbm_dat_o   = s_dat;
    assign fault_o     = (state_q == FAULT);
    assign fault_adr_o = fault_adr_q;

`ifdef WB_MUX_TMO_TIMEOUT_EN
    localparam int unsigned TW = $clog2(timeout + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Count stalled strobe cycles; the cycle that would reach `timeout`
    // fires tmo_hit unless the slave answers in that same cycle.
    always_comb begin
        tmo_cnt_d = '0;
        tmo_hit   = 1'b0;
        if (state_q == ACTIVE && wbm_cyc_i && wbm_stb_i && !(s_ack || s_err || s_rty)) begin
            tmo_hit   = (tmo_cnt_q == TW'(timeout - 1));
            tmo_cnt_d = tmo_hit ? '0 : tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Bus-cycle sequencing; a dropped cyc always wins over a timeout.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        fault_adr_d = fault_adr_q;
        case (state_q)
            IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    if (dec_hit) begin
                        sel_d   = dec_idx;
                        state_d = ACTIVE;
                    end else begin
                        fault_adr_d = wbm_adr_i;
                        state_d     = FAULT;
                    end
                end
            end
            ACTIVE: begin
                if (!wbm_cyc_i) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    fault_adr_d = wbm_adr_i;
                    state_d     = FAULT;
                end
            end
            FAULT: state_d = WAIT;
            WAIT: begin
                if (!wbm_cyc_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            fault_adr_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            fault_adr_q <= fault_adr_d;
        end
    end

endmodule

// File: tb/tb_wb_mux_tmo.sv
// Self-checking bench for wb_mux_tmo: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// bus-level model. Follows WB_MUX_TMO_TIMEOUT_EN if defined.
module tb_wb_mux_tmo;

    localparam int TIMEOUT = 8;
`ifdef WB_MUX_TMO_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic [31:0] wbm_adr_i = '0;
    logic [31:0] wbm_dat_i = '0;
    logic [3:0]  wbm_sel_i = '0;
    logic        wbm_we_i = 1'b0;
    logic        wbm_cyc_i = 1'b0;
    logic        wbm_stb_i = 1'b0;
    logic [2:0]  wbm_cti_i = '0;
    logic [1:0]  wbm_bte_i = '0;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [31:0] wbs_adr_o, wbs_dat_o;
    logic [3:0]  wbs_sel_o;
    logic        wbs_we_o;
    logic [2:0]  wbs_cti_o;
    logic [1:0]  wbs_bte_o;
    logic [1:0]  wbs_cyc_o, wbs_stb_o;
    logic [63:0] wbs_dat_i = '0;
    logic [1:0]  wbs_ack_i = '0, wbs_err_i = '0, wbs_rty_i = '0;
    logic        fault_o;
    logic [31:0] fault_adr_o;

    always #5 clk = ~clk;

    wb_mux_tmo #(
        .dw         (32),
        .aw         (32),
        .num_slaves (2),
        .match_addr ({32'h1000_0000, 32'h0000_0000}),
        .match_mask ({32'hF000_0000, 32'hF000_0000}),
        .timeout    (TIMEOUT)
    ) dut (
        .wb_clk_i (clk),         .wb_rst_i (wb_rst_i),
        .wbm_adr_i(wbm_adr_i),   .wbm_dat_i(wbm_dat_i),   .wbm_sel_i(wbm_sel_i),
        .wbm_we_i (wbm_we_i),    .wbm_cyc_i(wbm_cyc_i),   .wbm_stb_i(wbm_stb_i),
        .wbm_cti_i(wbm_cti_i),   .wbm_bte_i(wbm_bte_i),
        .wbm_dat_o(wbm_dat_o),   .wbm_ack_o(wbm_ack_o),   .wbm_err_o(wbm_err_o),
        .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o),   .wbs_dat_o(wbs_dat_o),   .wbs_sel_o(wbs_sel_o),
        .wbs_we_o (wbs_we_o),    .wbs_cti_o(wbs_cti_o),   .wbs_bte_o(wbs_bte_o),
        .wbs_cyc_o(wbs_cyc_o),   .wbs_stb_o(wbs_stb_o),
        .wbs_dat_i(wbs_dat_i),   .wbs_ack_i(wbs_ack_i),   .wbs_err_i(wbs_err_i),
        .wbs_rty_i(wbs_rty_i),
        .fault_o  (fault_o),     .fault_adr_o(fault_adr_o)
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A bus cycle is either free, connected to one slave, reporting an error
    // for one cycle, or blocked until the master releases cyc.
    logic [31:0] base [2];
    logic [31:0] mask [2];
    initial begin
        base[0] = 32'h0000_0000; mask[0] = 32'hF000_0000;
        base[1] = 32'h1000_0000; mask[1] = 32'hF000_0000;
    end

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 2; i++)
            if ((a & mask[i]) == base[i]) return i;
        return -1;
    endfunction

    int          m_slave = -1;
    bit          m_err_now = 1'b0;
    bit          m_blocked = 1'b0;
    int          m_stall = 0;
    logic [31:0] m_fadr = '0;
    int          m_dec;

    always @(posedge clk) begin
        if (!wb_rst_i) begin
            m_slave = -1; m_err_now = 1'b0; m_blocked = 1'b0; m_stall = 0; m_fadr = '0;
        end else if (m_err_now) begin
            m_err_now = 1'b0;
            m_blocked = 1'b1;
        end else if (m_blocked) begin
            if (!wbm_cyc_i) m_blocked = 1'b0;
        end else if (m_slave >= 0) begin
            if (!wbm_cyc_i) begin
                m_slave = -1; m_stall = 0;
            end else if (wbm_stb_i && !(wbs_ack_i[m_slave] || wbs_err_i[m_slave] || wbs_rty_i[m_slave])) begin
                m_stall++;
                if (TMO_EN && m_stall == TIMEOUT) begin
                    m_err_now = 1'b1; m_fadr = wbm_adr_i; m_slave = -1; m_stall = 0;
                end
            end else begin
                m_stall = 0;
            end
        end else if (wbm_cyc_i && wbm_stb_i) begin
            m_dec = decode(wbm_adr_i);
            if (m_dec >= 0) m_slave = m_dec;
            else begin m_err_now = 1'b1; m_fadr = wbm_adr_i; end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [1:0]  e_cyc, e_stb;
        logic        e_ack, e_err, e_rty;
        logic [31:0] e_dat;
        if (chk_en) begin
            e_cyc = '0; e_stb = '0; e_ack = 1'b0; e_err = m_err_now; e_rty = 1'b0; e_dat = '0;
            if (m_slave >= 0) begin
                e_cyc[m_slave] = wbm_cyc_i;
                e_stb[m_slave] = wbm_stb_i;
                e_ack = wbs_ack_i[m_slave];
                e_err = wbs_err_i[m_slave];
                e_rty = wbs_rty_i[m_slave];
                e_dat = wbs_dat_i[m_slave*32 +: 32];
            end
            chk("m_cyc", 64'(wbs_cyc_o), 64'(e_cyc));
            chk("m_stb", 64'(wbs_stb_o), 64'(e_stb));
            chk("m_ack", 64'(wbm_ack_o), 64'(e_ack));
            chk("m_err", 64'(wbm_err_o), 64'(e_err));
            chk("m_rty", 64'(wbm_rty_o), 64'(e_rty));
            chk("m_dat", 64'(wbm_dat_o), 64'(e_dat));
            chk("m_fault", 64'(fault_o), 64'(m_err_now));
            chk("m_fadr", 64'(fault_adr_o), 64'(m_fadr));
            chk("m_bcast", {wbs_adr_o, wbs_dat_o}, {wbm_adr_i, wbm_dat_i});
            chk("m_bcast2", 64'({wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o}),
                64'({wbm_sel_i, wbm_we_i, wbm_cti_i, wbm_bte_i}));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_slaves();
        wbs_ack_i = '0; wbs_err_i = '0; wbs_rty_i = '0;
    endtask

    task automatic req(input logic [31:0] a, input logic we, input logic [2:0] cti);
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1; wbm_adr_i = a; wbm_we_i = we; wbm_cti_i = cti;
        wbm_sel_i = 4'hF; wbm_dat_i = 32'h1234_5678;
    endtask

    task automatic release_bus();
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; quiet_slaves();
        tick(); tick();
    endtask

    function automatic logic [31:0] rand_adr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r[31:28] = 4'h0;
            1: r[31:28] = 4'h1;
            2: r[31:28] = 4'h3;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        int first_err;
        int acks;
        int ack_k;

        // reset
        tick();
        chk_en = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_cyc", 64'(wbs_cyc_o), 64'd0);
        chk("rst_err", 64'(wbm_err_o), 64'd0);
        chk("rst_dat", 64'(wbm_dat_o), 64'd0);
        chk("rst_fadr", 64'(fault_adr_o), 64'd0);
        tick();
        wb_rst_i = 1'b1;
        tick();

        // mapped read to slave 1
        quiet_slaves();
        req(32'h1000_0004, 1'b0, 3'b000);
        @(negedge clk);
        chk("rd_c0_cyc", 64'(wbs_cyc_o), 64'd0);
        tick();
        @(negedge clk);
        chk("rd_c1_cyc", 64'(wbs_cyc_o), 64'b10);
        chk("rd_c1_ack", 64'(wbm_ack_o), 64'd0);
        tick();
        wbs_ack_i = 2'b10; wbs_dat_i[63:32] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rd_ack", 64'(wbm_ack_o), 64'd1);
        chk("rd_dat", 64'(wbm_dat_o), 64'hDEAD_BEEF);
        tick();
        wbs_ack_i = '0; wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        @(negedge clk);
        chk("rd_end_ack", 64'(wbm_ack_o), 64'd0);
        tick();

        // unmapped write
        req(32'h3000_0000, 1'b1, 3'b000);
        @(negedge clk);
        chk("um_c0_err", 64'(wbm_err_o), 64'd0);
        tick();
        @(negedge clk);
        chk("um_err", 64'(wbm_err_o), 64'd1);
        chk("um_fault", 64'(fault_o), 64'd1);
        chk("um_cyc", 64'(wbs_cyc_o), 64'd0);
        chk("um_fadr", 64'(fault_adr_o), 64'h3000_0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            chk("um_wait", 64'({wbm_err_o, fault_o, wbs_cyc_o}), 64'd0);
        end
        release_bus();

        // stalled slave 0
        req(32'h0000_0100, 1'b0, 3'b000);
        first_err = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            @(negedge clk);
            if (wbm_err_o && first_err == 0) begin
                first_err = k;
                chk("tmo_drop_cyc", 64'(wbs_cyc_o), 64'd0);
                chk("tmo_fadr", 64'(fault_adr_o), 64'h0000_0100);
            end
        end
        chk("tmo_first_err", 64'(first_err), TMO_EN ? 64'd9 : 64'd0);
        chk("tmo_end_cyc", 64'(wbs_cyc_o), TMO_EN ? 64'd0 : 64'b01);
        release_bus();

        // incrementing burst to slave 0, last beat addresses slave 1's range
        req(32'h0000_0000, 1'b1, 3'b010);
        tick();
        acks = 0;
        wbs_ack_i = 2'b01;
        for (int b = 0; b < 4; b++) begin
            wbm_adr_i = (b == 3) ? 32'h1000_0000 : 32'(b * 4);
            wbm_cti_i = (b == 3) ? 3'b111 : 3'b010;
            @(negedge clk);
            chk("burst_cyc", 64'(wbs_cyc_o), 64'b01);
            if (wbm_ack_o) acks++;
            tick();
        end
        chk("burst_acks", 64'(acks), 64'd4);
        release_bus();

        // reset while active mid-burst
        req(32'h0000_0040, 1'b0, 3'b010);
        tick(); tick();
        wb_rst_i = 1'b0;
        tick();
        @(negedge clk);
        chk("rstmid_cyc", 64'(wbs_cyc_o), 64'd0);
        chk("rstmid_resp", 64'({wbm_ack_o, wbm_err_o}), 64'd0);
        chk("rstmid_fadr", 64'(fault_adr_o), 64'd0);
        wb_rst_i = 1'b1;
        release_bus();

        // ack arriving in the very cycle the stall count reaches timeout
        req(32'h0000_0200, 1'b0, 3'b000);
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (k == TIMEOUT) wbs_ack_i = 2'b01;
        end
        @(negedge clk);
        chk("coin_ack", 64'(wbm_ack_o), 64'd1);
        chk("coin_fault", 64'(fault_o), 64'd0);
        tick();
        quiet_slaves(); wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        @(negedge clk);
        chk("coin_fault_next", 64'({fault_o, wbm_err_o}), 64'd0);
        release_bus();

        // randomized traffic in three response-rate phases
        for (int n = 0; n < 3000; n++) begin
            tick();
            wb_rst_i = ($urandom_range(0, 299) != 0);
            if (!wbm_cyc_i) begin
                if ($urandom_range(0, 2) == 0) begin
                    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
            end else begin
                wbm_stb_i = ($urandom_range(0, 5) != 0);
            end
            wbm_adr_i = rand_adr();
            wbm_dat_i = $urandom;
            wbm_sel_i = 4'($urandom);
            wbm_we_i  = 1'($urandom);
            wbm_cti_i = 3'($urandom);
            wbm_bte_i = 2'($urandom);
            ack_k = (n < 1000) ? 1 : (n < 2000) ? 12 : 3;
            for (int s = 0; s < 2; s++) begin
                wbs_ack_i[s] = ($urandom_range(0, ack_k) == 0);
                wbs_err_i[s] = (n >= 2000) && ($urandom_range(0, 15) == 0);
                wbs_rty_i[s] = (n >= 2000) && ($urandom_range(0, 15) == 0);
            end
            wbs_dat_i = {$urandom, $urandom};
        end
        wb_rst_i = 1'b1;
        release_bus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
